// File: rtl/seq_divider_4bit_if.sv
// Start/busy/done handshake bundle between the datapath and the 4-bit divider.
interface seq_divider_4bit_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_4bit.sv
// Multi-cycle unsigned 4-bit restoring divider built around one shared
// ripple adder-subtractor that is reused on every iteration.
module Four_Bit_Adder_Subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic       c_out,
    output logic [3:0] sum
);
    logic [4:0] c;
    logic [3:0] bx;

    // c_in doubles as the mode bit: invert b and add one for a - b
    assign bx   = b ^ {4{c_in}};
    assign c[0] = c_in;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            assign sum[i]  = a[i] ^ bx[i] ^ c[i];
            assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    endgenerate

    assign c_out = c[4];
endmodule

module seq_divider_4bit #(
    parameter logic [3:0] DBZ_QUOTIENT = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    seq_divider_4bit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] d_reg, q_reg, r_reg;
    logic [1:0] step;
    logic [3:0] trial, diff, r_next, q_next;
    logic       no_borrow;
    logic [3:0] quotient_r, remainder_r;
    logic       dbz_r;

    // R stays <= 7 before the shift, so trial always fits in 4 bits
    assign trial = {r_reg[2:0], q_reg[3]};

    Four_Bit_Adder_Subtractor u_sub (
        .a     (trial),
        .b     (d_reg),
        .c_in  (1'b1),
        .c_out (no_borrow),
        .sum   (diff)
    );

    assign r_next = no_borrow ? diff : trial;
    assign q_next = {q_reg[2:0], no_borrow};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = (bus.divisor == 4'd0) ? DONE : CALC;
            CALC: if (step == 2'd3) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            step        <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.divisor == 4'd0) begin
                        quotient_r  <= DBZ_QUOTIENT;
                        remainder_r <= bus.dividend;
                        dbz_r       <= 1'b1;
                    end else begin
                        d_reg <= bus.divisor;
                        q_reg <= bus.dividend;
                        r_reg <= '0;
                        step  <= '0;
                        dbz_r <= 1'b0;
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    step  <= step + 2'd1;
                    if (step == 2'd3) begin
                        quotient_r  <= q_next;
                        remainder_r <= r_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state == CALC);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider_4bit.sv
// Bench for seq_divider_4bit: cycle model from the handshake timing rules plus
// integer arithmetic, checked every cycle, with directed literal expectations.
module tb_seq_divider_4bit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   dones = 0;
    bit   chk_en = 1'b0;

    seq_divider_4bit_if bus ();

    seq_divider_4bit #(.DBZ_QUOTIENT(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: expected outputs for the cycle following each rising edge.
    logic       m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [3:0] m_q = '0, m_r = '0, pq = '0, pr = '0;
    int         pend = 0;
    bit         idle;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_q = 0; m_r = 0; pend = 0;
        end else begin
            idle = (pend == 0) && !m_done;
            m_done = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    m_done = 1; m_busy = 0; m_q = pq; m_r = pr;
                end
            end else if (idle && bus.start) begin
                if (bus.divisor == 4'd0) begin
                    m_done = 1; m_q = 4'hF; m_r = bus.dividend; m_dbz = 1;
                end else begin
                    pend = 4; m_busy = 1; m_dbz = 0;
                    pq = bus.dividend / bus.divisor;
                    pr = bus.dividend % bus.divisor;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic cmpi(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", {3'b0, bus.busy}, {3'b0, m_busy});
            cmp("done", {3'b0, bus.done}, {3'b0, m_done});
            cmp("quotient", bus.quotient, m_q);
            cmp("remainder", bus.remainder, m_r);
            cmp("div_by_zero", {3'b0, bus.div_by_zero}, {3'b0, m_dbz});
            if (bus.done === 1'b1) dones++;
        end
    end

    // Advances at least one negedge, stops at the first negedge with done high.
    task automatic wait_done(input int bound, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.done !== 1'b1 && lat < bound);
        cmp("done_seen", {3'b0, bus.done}, 4'd1);
    endtask

    task automatic expect_res(input string tag, input logic [3:0] eq, input logic [3:0] er, input logic edbz);
        cmp({tag, "_q"}, bus.quotient, eq);
        cmp({tag, "_r"}, bus.remainder, er);
        cmp({tag, "_dbz"}, {3'b0, bus.div_by_zero}, {3'b0, edbz});
        cmp({tag, "_model_q"}, m_q, eq);
        cmp({tag, "_model_r"}, m_r, er);
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic edbz);
        int lat;
        @(negedge clk);
        bus.dividend = a; bus.divisor = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.done === 1'b1) lat = 1;
        else begin
            wait_done(20, lat);
            lat++;
        end
        cmpi({tag, "_latency"}, lat, (b == 4'd0) ? 1 : 5);
        expect_res(tag, eq, er, edbz);
    endtask

    initial begin
        int lat, d0, last_done;
        rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        cmp("reset_busy", {3'b0, bus.busy}, 4'd0);
        cmp("reset_done", {3'b0, bus.done}, 4'd0);
        expect_res("reset", 4'd0, 4'd0, 1'b0);
        rst = 1'b0;

        run_op("d10_3", 4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
        run_op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        run_op("d7_15", 4'd7, 4'd15, 4'd0, 4'd7, 1'b0);
        run_op("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
        run_op("d9_0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1);
        run_op("d8_2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0);

        // Operand change and extra start during CALC must not disturb 14/5
        @(negedge clk);
        d0 = dones;
        bus.dividend = 4'd14; bus.divisor = 4'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.dividend = 4'd3; bus.divisor = 4'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(20, lat);
        expect_res("d14_5", 4'd2, 4'd4, 1'b0);
        repeat (4) @(negedge clk);
        cmpi("d14_5_done_count", dones - d0, 1);

        // Reset in the second CALC cycle
        bus.dividend = 4'd13; bus.divisor = 4'd4; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("rst_mid_busy", {3'b0, bus.busy}, 4'd0);
        cmp("rst_mid_done", {3'b0, bus.done}, 4'd0);
        expect_res("rst_mid", 4'd0, 4'd0, 1'b0);
        run_op("d13_4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0);

        // Exhaustive sweep with start held high
        @(negedge clk);
        d0 = dones;
        last_done = 0;
        bus.start = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                bus.dividend = 4'(a); bus.divisor = 4'(b);
                wait_done(20, lat);
                cmpi("sweep_gap", lat, ((a == 0 && b == 0) ? 0 : 1) + ((b == 0) ? 1 : 5));
                if (b == 0) expect_res("sweep_dbz", 4'hF, 4'(a), 1'b1);
                else        expect_res("sweep", 4'(a / b), 4'(a % b), 1'b0);
                last_done++;
            end
        end
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        cmpi("sweep_done_count", dones - d0, last_done);
        cmp("idle_busy", {3'b0, bus.busy}, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
